// File: rtl/recv_pkg.sv
// Shared types and defaults for the FIFO read-side byte packer.
// Optional partial-word timeout is enabled with the PACK_TIMEOUT_EN macro.
package recv_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

   localparam int DATA_W_DEF  = 8;
   localparam int PACK_N_DEF  = 4;
   localparam int TIMEOUT_DEF = 16;

   // Width of a counter that must hold every value from 0 up to and including n.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pack_timer.sv
// Idle counter for the packer: pulses expired on the TIMEOUT-th consecutive idle cycle.
// Only instantiated when PACK_TIMEOUT_EN is defined.
module pack_timer
   import recv_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk_r,
   input  logic reset,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam int TW = cnt_width(TIMEOUT);

   logic [TW-1:0] idle_cnt;

   assign expired = count_en && !clear && (idle_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk_r or posedge reset) begin
      if (reset) begin
         idle_cnt <= '0;
      end else if (clear || expired) begin
         idle_cnt <= '0;
      end else if (count_en) begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Reads bytes from a FIFO (data one cycle after rd_en) and packs PACK_N of them, first byte lowest.
// Define PACK_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module fifo_rd_packer
   import recv_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PACK_N  = PACK_N_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                     clk_r,
   input  logic                     reset,
   input  logic                     underflow,
   input  logic [DATA_W-1:0]        data_r,
   output logic                     rd_en,
   output logic [DATA_W*PACK_N-1:0] word_o,
   output logic [PACK_N-1:0]        word_keep,
   output logic                     word_valid,
   input  logic                     word_ready,
   output state_e                   state_dbg
);

   localparam int CNT_W = cnt_width(PACK_N);

   if (PACK_N < 2 || PACK_N > 8 || TIMEOUT < 1) begin : g_param_check
      $error("fifo_rd_packer: PACK_N must be 2..8 and TIMEOUT at least 1");
   end

   state_e           state;
   logic [CNT_W-1:0] issue_cnt;
   logic [CNT_W-1:0] cap_cnt;
   logic             rd_pend;
   logic             capture;
   logic             last_cap;
   logic             handshake;
   logic             flush;

   // Output handshake: a word transfers on any clk_r edge with word_valid && word_ready;
   // word_o/word_keep/word_valid never change while word_valid=1 and word_ready=0.
   assign handshake = word_valid && word_ready;

   // Reads are only issued in FILL; a read issued last cycle is always captured.
   assign rd_en    = !reset && (state == FILL) && !underflow && (issue_cnt < CNT_W'(PACK_N));
   assign capture  = rd_pend;
   assign last_cap = capture && (cap_cnt == CNT_W'(PACK_N - 1));

   assign state_dbg = state;

`ifdef PACK_TIMEOUT_EN
   logic idle;
   logic expired;

   assign idle = (state == FILL) && (cap_cnt != '0) && (cap_cnt < CNT_W'(PACK_N)) &&
                 !rd_pend && !rd_en;

   pack_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_pack_timer (
      .clk_r    (clk_r),
      .reset    (reset),
      .count_en (idle),
      .clear    (capture || handshake),
      .expired  (expired)
   );

   assign flush = expired;
`else
   assign flush = 1'b0;
`endif

   always_ff @(posedge clk_r or posedge reset) begin
      if (reset) begin
         state      <= FILL;
         rd_pend    <= 1'b0;
         issue_cnt  <= '0;
         cap_cnt    <= '0;
         word_o     <= '0;
         word_keep  <= '0;
         word_valid <= 1'b0;
      end else begin
         rd_pend <= rd_en;
         if (rd_en) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
         end
         case (state)
            FILL: begin
               if (capture) begin
                  for (int k = 0; k < PACK_N; k++) begin
                     if (cap_cnt == CNT_W'(k)) begin
                        word_o[k*DATA_W +: DATA_W] <= data_r;
                     end
                  end
                  cap_cnt <= cap_cnt + CNT_W'(1);
                  if (last_cap) begin
                     state      <= FULL;
                     word_valid <= 1'b1;
                     word_keep  <= '1;
                  end
               end else if (flush) begin
                  // Partial flush: keep marks only the lanes actually captured.
                  state      <= FULL;
                  word_valid <= 1'b1;
                  word_keep  <= PACK_N'((32'd1 << cap_cnt) - 32'd1);
               end
            end
            FULL: begin
               if (handshake) begin
                  state      <= FILL;
                  word_valid <= 1'b0;
                  word_keep  <= '0;
                  word_o     <= '0;
                  issue_cnt  <= '0;
                  cap_cnt    <= '0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
